// File: rtl/add8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit prefix adder among N_REQ requesters.
// Results land in a one-entry tagged response slot with valid/ready handshake.

module prefix_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  logic [7:0] g0, p0;
  logic [7:0] g1, p1;
  logic [7:0] g2, p2;
  logic [7:0] g3;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Kogge-Stone carry tree: spans of 1, 2, 4
  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
  end

  always_comb begin
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
  end

  always_comb begin
    g3 = g2;
    for (int i = 4; i < 8; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end
  end

  assign sum = p0 ^ {g3[6:0], 1'b0};

endmodule

module add8_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sum,
  output logic [15:0]          op_count
);

  localparam int IW = ID_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] sel_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [7:0]      rsp_sum_q;
  logic [15:0]     op_count_q;

  logic            slot_free;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [IW-1:0]   cand;
  logic            accept;
  logic [ID_W-1:0] sel;
  logic [IW-1:0]   ptr_inc;
  logic [ID_W-1:0] ptr_d;
  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [7:0]      add_sum;
  logic [N_REQ-1:0] gnt_oh;

  assign slot_free = (state_q == EMPTY) || rsp_ready;

  // First valid requester at or after ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + IW'(k);
      if (cand >= IW'(N_REQ)) begin
        cand = cand - IW'(N_REQ);
      end
      if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign accept = gnt_any && slot_free && rst_n;

  always_comb begin
    gnt_oh = '0;
    if (accept) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = gnt_oh;

  assign sel   = accept ? gnt_idx : sel_q;
  assign add_a = req_a[{sel, 3'b000} +: 8];
  assign add_b = req_b[{sel, 3'b000} +: 8];

  prefix_add8 u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    ptr_inc = {1'b0, gnt_idx} + IW'(1);
    ptr_d   = ptr_inc[ID_W-1:0];
    if (ptr_inc >= IW'(N_REQ)) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      sel_q      <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      op_count_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) state_q <= FULL;
        end
        FULL: begin
          if (!accept && rsp_ready) state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        rsp_sum_q  <= add_sum;
        rsp_id_q   <= gnt_idx;
        sel_q      <= gnt_idx;
        ptr_q      <= ptr_d;
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/add8_rr_arbiter.md
Name: add8_rr_arbiter

Overview:
Shares one prefix_add8 instance (ports a, b, sum; 8-bit, sum mod 256, no carry out) among N_REQ requesters.
- Round-robin arbitration selects one requester per cycle.
- The chosen operand pair drives the shared adder.
- The sum is captured in a one-entry response register, tagged with the requester index.
- Valid/ready handshake on both the request side and the response side.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must equal clog2(N_REQ)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  N_REQ  bit i: requester i presents an operand pair
req_a  input  8*N_REQ  operand A; requester i uses bits [8i+7:8i]
req_b  input  8*N_REQ  operand B; requester i uses bits [8i+7:8i]
req_ready  output  N_REQ  one-hot grant; a transfer occurs on req_valid[i] && req_ready[i]
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer accepts the response this cycle
rsp_id  output  ID_W  index of the requester whose sum is held
rsp_sum  output  8  held sum (a+b) mod 256
op_count  output  16  number of accepted requests, wraps at 65535->0

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, op_count=0.
  - Priority pointer = 0.
  - req_ready=0 while reset is asserted.
- Reset mid-operation drops any held response without delivering it.
- Slot state, 2-state FSM:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Slot free condition: slot_free = EMPTY || (FULL && rsp_ready). Simultaneous pop and push is allowed, giving full throughput of one op per cycle.
- Grant (combinational):
  - If slot_free and any req_valid: grant the first valid requester scanning ptr, ptr+1, ..., wrapping mod N_REQ.
  - req_ready is one-hot on the granted index; otherwise all zero.
  - req_ready never asserts for a requester whose req_valid is low.
- Datapath:
  - Granted req_a/req_b slices are muxed into the single prefix_add8.
  - When no grant, mux select holds the last granted index; the adder output is ignored.
- On an accepted transfer:
  - rsp_sum <= adder sum; rsp_id <= granted index; state -> FULL.
  - ptr <= (granted index + 1) mod N_REQ.
  - op_count <= op_count + 1.
- Latency: request accepted at edge k; rsp_valid=1 with the result from edge k onward, visible in cycle k+1.
- FULL, rsp_ready=1, no new grant: state -> EMPTY at next edge; rsp_sum/rsp_id hold their last value.
- FULL, rsp_ready=0: rsp_sum and rsp_id stay stable; req_ready all zero (backpressure).
- Pointer only moves on an accepted transfer. Idle cycles do not rotate priority.
- Requesters must hold req_a/req_b stable while req_valid is high and not granted. Operands are sampled only at the grant edge.
- Arithmetic: 8-bit wrap, no carry or overflow flag (e.g. 200+100 -> 44).
- rsp_ready while EMPTY has no effect.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with a held response -> rsp_valid=0, rsp_sum=0, op_count=0 immediately; first grant after release goes to requester 0.
- Single requester: req 1 with a=100, b=24, rsp_ready=1 -> req_ready=4'b0010 for one cycle; next cycle rsp_valid=1, rsp_id=1, rsp_sum=124; op_count=1.
- Round-robin fairness: all four valid continuously, with pairs (20,178), (177,54), (90,60), (24,76), rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; sums 198, 231, 150, 100 with matching rsp_id; one result per cycle.
- Backpressure: rsp_ready=0 after the first result -> rsp_sum/rsp_id stable and req_ready=0 for 5 cycles; raising rsp_ready gives the next grant in the same cycle, with no lost or duplicated response.
- Wrap-around: a=200, b=100 -> rsp_sum=44. a=255, b=1 -> 0. op_count preloaded by running 65536 ops -> returns to 0.
- Sparse priority: ptr=2, only requesters 0 and 3 valid -> grant 3 first, then 0; ptr then = 1.
